vga_pattern_gen: RTL
====================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter TOTAL_COLS, default 800, meaning pixel clocks per line.
REQ-002 SHALL have parameter TOTAL_ROWS, default 525, meaning lines per frame.
REQ-003 SHALL have parameter ACTIVE_COLS, default 640, meaning visible columns; it must be a multiple of 16.
REQ-004 SHALL have parameter ACTIVE_ROWS, default 480, meaning visible rows; it must be a multiple of 16.
REQ-005 SHALL have port i_Clk, input, 1 bit: the single pixel clock; all logic runs on its rising edge.
REQ-006 SHALL have port i_Rst_L, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port i_Mode, input, 2 bits: pattern select (0 vertical bars, 1 solid, 2 horizontal bars, 3 black).
REQ-008 SHALL have port i_Solid_Color, input, 9 bits: RrrGggBbb colour used in mode 1.
REQ-009 SHALL have port o_HSync, output, 1 bit: high while the output column is below ACTIVE_COLS.
REQ-010 SHALL have port o_VSync, output, 1 bit: high while the output row is below ACTIVE_ROWS.
REQ-011 SHALL have port o_RrrGggBbb, output, 9 bits: pixel colour, with R in [8:6], G in [5:3] and B in [2:0].
REQ-012 SHALL have ports o_Col_Count (10 bits) and o_Row_Count (10 bits), outputs: the pixel position aligned with the other outputs.

Function
REQ-013 SHALL keep an internal column counter running 0..TOTAL_COLS-1 that wraps to 0.
REQ-014 SHALL increment the internal row counter on column wrap, and wrap the row counter from TOTAL_ROWS-1 to 0 on the column wrap at the end of the last line.
REQ-015 SHALL register all outputs, giving a 1-cycle latency from the internal counter state, with o_HSync, o_VSync, o_RrrGggBbb, o_Col_Count and o_Row_Count all describing the same pixel.
REQ-016 SHALL force o_RrrGggBbb to 9'h000 whenever o_HSync or o_VSync is 0, in every mode.
REQ-017 SHALL compute the bar index without a divider, using a sub-counter (0..ACTIVE_COLS/16-1) and a 4-bit bar index, both cleared at column 0; in mode 0, bar index = column / (ACTIVE_COLS/16).
REQ-018 SHALL, in mode 2, step a row-based index every ACTIVE_ROWS/16 active lines using the same no-divider scheme, cleared at row 0.
REQ-019 SHALL map a palette index p to colour as follows, with p[2]=R, p[1]=G, p[0]=B:
- a channel with its bit set = 3'b111 if p[3]=1, else 3'b100;
- a channel with its bit clear = 3'b000.
REQ-020 SHALL, in mode 1, output i_Solid_Color unmodified in the active region.
REQ-021 SHALL sample i_Mode only when the internal counters are at column 0, row 0; a change at any other time takes effect at the next frame start, so no tearing occurs.
REQ-022 SHALL sample i_Solid_Color every cycle with no latching.

Reset
REQ-023 SHALL, while i_Rst_L=0, clear all counters, the latched mode (to 0), and all outputs (to 0), asynchronously.
REQ-024 SHALL restart from column 0, row 0 on the first rising edge after i_Rst_L deasserts, including when reset was asserted mid-line or mid-frame.

Configuration
REQ-025 SHALL, when macro VGA_COLOR_CYCLE_EN is defined:
- keep a 6-bit frame counter that increments at each frame wrap and wraps modulo 64;
- use palette index (bar or row index + frame_cnt[5:2]) mod 16 in modes 0 and 2.
REQ-026 SHALL, when VGA_COLOR_CYCLE_EN is undefined, have no frame counter and a palette offset of 0.

Verification
REQ-027 SHALL pass: release reset, mode 0 -> first output cycle shows col 0, row 0, HSync=1, VSync=1, colour 9'h000; col 40 -> 9'h004; col 360 (index 9) -> 9'h007; col 639 -> 9'h1FF.
REQ-028 SHALL pass: run to col 640 and col 799 of row 0 -> HSync=0, VSync=1, colour 9'h000; the next cycle shows col 0, row 1.
REQ-029 SHALL pass: mode 2 -> rows 0-29 show 9'h000, rows 30-59 show 9'h004, and row 479 shows 9'h1FF; row 480 shows VSync=0, colour 0; after 420000 cycles the output returns to col 0, row 0.
REQ-030 SHALL pass: switch i_Mode 0->1 at row 100 with i_Solid_Color=9'h0F0 -> the bars persist to the end of the frame, and the next frame shows 9'h0F0 throughout the active area.
REQ-031 SHALL pass: assert i_Rst_L=0 at col 300, row 200 -> outputs go to 0 immediately without waiting for a clock; after release, counting restarts at col 0, row 0.
REQ-032 SHALL pass, with VGA_COLOR_CYCLE_EN defined: in mode 0, frames 0-3 show col 0 = 9'h000 and frame 4 shows col 0 = 9'h004.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
//   Test-pattern generator for a VGA-style raster. It scans a column/row
//   raster and paints one of four patterns into the visible area:
//   vertical colour bars, a solid colour, horizontal colour bars, or black.
//
//   Every output is registered. Each output cycle describes one pixel
//   position, one clock after the internal counters were at that position.
//
//   Optional feature (macro VGA_COLOR_CYCLE_EN):
//     When defined, a 6-bit frame counter advances once per frame. Its top
//     four bits are added to the palette index in both bar modes, so the
//     bar colours rotate by one step every four frames.
//     When undefined, there is no frame counter and the offset is zero.
//
// Parameters
//   TOTAL_COLS  pixel clocks per line (blanking included)
//   TOTAL_ROWS  lines per frame (blanking included)
//   ACTIVE_COLS visible columns; must be a multiple of 16
//   ACTIVE_ROWS visible rows; must be a multiple of 16
//
// Ports
//   i_Clk          pixel clock; all logic runs on the rising edge
//   i_Rst_L        asynchronous active-low reset
//   i_Mode         pattern select: 0 vbars, 1 solid, 2 hbars, 3 black.
//                  Sampled only at the start of a frame.
//   i_Solid_Color  RrrGggBbb colour for mode 1; sampled every cycle
//   o_HSync        high while the output column is in the visible area
//   o_VSync        high while the output row is in the visible area
//   o_RrrGggBbb    pixel colour: R [8:6], G [5:3], B [2:0]
//   o_Col_Count    column of the pixel the other outputs describe
//   o_Row_Count    row of the pixel the other outputs describe
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [1:0] i_Mode,
  input  logic [8:0] i_Solid_Color,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [8:0] o_RrrGggBbb,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count
);

  typedef enum logic [1:0] {
    MODE_VBARS = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_HBARS = 2'd2,
    MODE_BLACK = 2'd3
  } mode_t;

  localparam logic [9:0] COL_LAST     = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST     = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] COL_ACT      = 10'(ACTIVE_COLS);
  localparam logic [9:0] ROW_ACT      = 10'(ACTIVE_ROWS);
  localparam logic [9:0] COL_SUB_LAST = 10'(ACTIVE_COLS / 16 - 1);
  localparam logic [9:0] ROW_SUB_LAST = 10'(ACTIVE_ROWS / 16 - 1);

  logic [9:0] col;
  logic [9:0] row;
  logic [9:0] col_sub;
  logic [3:0] col_bar;
  logic [9:0] row_sub;
  logic [3:0] row_bar;
  logic       col_wrap;
  logic       frame_wrap;
  logic       frame_start;
  logic       active;
  mode_t      mode_q;
  mode_t      mode_eff;
  logic [3:0] pal_offset;
  logic [3:0] pal_idx;
  logic [8:0] pixel;

  // Palette: each of p[2:0] enables R, G, B; p[3] selects full or half level.
  function automatic logic [8:0] palette(input logic [3:0] p);
    logic [2:0] level;
    level = p[3] ? 3'b111 : 3'b100;
    return {p[2] ? level : 3'b000,
            p[1] ? level : 3'b000,
            p[0] ? level : 3'b000};
  endfunction

  assign col_wrap    = (col == COL_LAST);
  assign frame_wrap  = col_wrap && (row == ROW_LAST);
  assign frame_start = (col == 10'd0) && (row == 10'd0);
  assign active      = (col < COL_ACT) && (row < ROW_ACT);

  // Raster counters. The sub-counters divide the position into 16 equal
  // bands without a divider: each band index steps when its sub-counter
  // reaches the band width. Past the visible area the band indices keep
  // stepping and may wrap, which is harmless because the colour is blanked.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      col     <= '0;
      row     <= '0;
      col_sub <= '0;
      col_bar <= '0;
      row_sub <= '0;
      row_bar <= '0;
    end else if (col_wrap) begin
      col     <= '0;
      col_sub <= '0;
      col_bar <= '0;
      if (row == ROW_LAST) begin
        row     <= '0;
        row_sub <= '0;
        row_bar <= '0;
      end else begin
        row <= row + 10'd1;
        if (row_sub == ROW_SUB_LAST) begin
          row_sub <= '0;
          row_bar <= row_bar + 4'd1;
        end else begin
          row_sub <= row_sub + 10'd1;
        end
      end
    end else begin
      col <= col + 10'd1;
      if (col_sub == COL_SUB_LAST) begin
        col_sub <= '0;
        col_bar <= col_bar + 4'd1;
      end else begin
        col_sub <= col_sub + 10'd1;
      end
    end
  end

  // The mode is captured at the frame's first pixel. That pixel already
  // uses the freshly sampled value, so the whole frame shows one pattern.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mode_q <= MODE_VBARS;
    end else if (frame_start) begin
      mode_q <= mode_t'(i_Mode);
    end
  end

  assign mode_eff = frame_start ? mode_t'(i_Mode) : mode_q;

`ifdef VGA_COLOR_CYCLE_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 6'd1;
    end
  end

  // Rotate bar colours by one palette step every four frames.
  assign pal_offset = frame_cnt[5:2];
`else
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
  assign pal_offset        = 4'd0;
`endif

  always_comb begin
    pal_idx = 4'd0;
    pixel   = 9'h000;
    if (active) begin
      case (mode_eff)
        MODE_VBARS: begin
          pal_idx = col_bar + pal_offset;
          pixel   = palette(pal_idx);
        end
        MODE_SOLID: pixel = i_Solid_Color;
        MODE_HBARS: begin
          pal_idx = row_bar + pal_offset;
          pixel   = palette(pal_idx);
        end
        MODE_BLACK: pixel = 9'h000;
        default:    pixel = 9'h000;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_HSync     <= 1'b0;
      o_VSync     <= 1'b0;
      o_RrrGggBbb <= 9'h000;
      o_Col_Count <= '0;
      o_Row_Count <= '0;
    end else begin
      o_HSync     <= (col < COL_ACT);
      o_VSync     <= (row < ROW_ACT);
      o_RrrGggBbb <= pixel;
      o_Col_Count <= col;
      o_Row_Count <= row;
    end
  end

endmodule
